// File: rtl/rv32_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : rv32_alu_issue
// Brief    : RV32I decode/issue stage driving a registered ALU; owns RF and WB.
// Revision : 1.0
// ============================================================================
module rv32_alu_issue #(
  parameter int XLEN       = 32,
  parameter int RF_CLR_RST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_instr_valid,
  input  logic [31:0]     i_instr,
  input  logic [31:0]     i_instr_pc,
  output logic            o_instr_ready,
  output logic            o_illegal,
  output logic            o_alu_enable,
  output logic [3:0]      o_alu_opsel,
  output logic [31:0]     o_alu_code_bus,
  output logic [31:0]     o_alu_pc,
  output logic [XLEN-1:0] o_alu_s1,
  output logic [XLEN-1:0] o_alu_s2,
  input  logic [XLEN-1:0] i_alu_result,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data
);

  localparam logic [6:0] c_OPC_R     = 7'b0110011;
  localparam logic [6:0] c_OPC_I     = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

  logic [XLEN-1:0] r_rf [32];

  logic            r_ex_valid;
  logic [4:0]      r_ex_rd;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic            r_illegal;
  logic [3:0]      r_opsel;
  logic [31:0]     r_code_bus;
  logic [31:0]     r_pc;
  logic [XLEN-1:0] r_s1;
  logic [XLEN-1:0] r_s2;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_legal;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic [3:0]      w_opsel;
  logic [XLEN-1:0] w_s1;
  logic [XLEN-1:0] w_s2;
  logic            w_hazard;
  logic            w_ready;
  logic            w_accept;
  logic            w_issue;

  assign w_opc = i_instr[6:0];
  assign w_rd  = i_instr[11:7];
  assign w_f3  = i_instr[14:12];
  assign w_rs1 = i_instr[19:15];
  assign w_rs2 = i_instr[24:20];
  assign w_f7  = i_instr[31:25];

  always_comb begin
    w_legal   = 1'b1;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_opsel   = 4'd0;
    case (w_opc)
      c_OPC_R: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        case (w_f3)
          3'b000: begin
            if (w_f7 == 7'h20)      w_opsel = 4'd1;
            else if (w_f7 != 7'h00) w_legal = 1'b0;
          end
          3'b111:  w_opsel = 4'd2;
          3'b110:  w_opsel = 4'd3;
          3'b100:  w_opsel = 4'd4;
          3'b010:  w_opsel = 4'd5;
          3'b011:  w_opsel = 4'd6;
          default: w_legal = 1'b0;
        endcase
        if (w_f3 != 3'b000 && w_f7 != 7'h00) w_legal = 1'b0;
      end
      c_OPC_I: begin
        w_use_rs1 = 1'b1;
        case (w_f3)
          3'b000:  w_opsel = 4'd7;
          3'b111:  w_opsel = 4'd9;
          3'b110:  w_opsel = 4'd10;
          3'b100:  w_opsel = 4'd11;
          3'b010:  w_opsel = 4'd12;
          3'b011:  w_opsel = 4'd13;
          default: w_legal = 1'b0;
        endcase
      end
      c_OPC_LUI:   w_opsel = 4'd14;
      c_OPC_AUIPC: w_opsel = 4'd15;
      default:     w_legal = 1'b0;
    endcase
    // Illegal words read nothing, so they can never stall on a hazard.
    if (!w_legal) begin
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
    end
  end

  // Register read with WB bypass: the value being written this cycle wins.
  always_comb begin
    w_s1 = '0;
    w_s2 = '0;
    if (w_use_rs1 && w_rs1 != 5'd0)
      w_s1 = (r_wb_valid && r_wb_rd == w_rs1) ? i_alu_result : r_rf[w_rs1];
    if (w_use_rs2 && w_rs2 != 5'd0)
      w_s2 = (r_wb_valid && r_wb_rd == w_rs2) ? i_alu_result : r_rf[w_rs2];
  end

  assign w_hazard = r_ex_valid && (r_ex_rd != 5'd0) &&
                    ((w_use_rs1 && w_rs1 == r_ex_rd) || (w_use_rs2 && w_rs2 == r_ex_rd));
  assign w_ready  = rst_n && !w_hazard;
  assign w_accept = i_instr_valid && w_ready;
  assign w_issue  = w_accept && w_legal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_rd    <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_illegal  <= 1'b0;
      r_opsel    <= 4'd0;
      r_code_bus <= 32'd0;
      r_pc       <= 32'd0;
      r_s1       <= '0;
      r_s2       <= '0;
    end else begin
      r_ex_valid <= w_issue;
      r_illegal  <= w_accept && !w_legal;
      if (w_issue) begin
        r_ex_rd    <= w_rd;
        r_opsel    <= w_opsel;
        r_code_bus <= i_instr;
        r_pc       <= i_instr_pc;
        r_s1       <= w_s1;
        r_s2       <= w_s2;
      end
      r_wb_valid <= r_ex_valid && (r_ex_rd != 5'd0);
      r_wb_rd    <= r_ex_valid ? r_ex_rd : 5'd0;
    end
  end

  generate
    if (RF_CLR_RST != 0) begin : g_rf_clr
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (r_wb_valid) begin
          r_rf[r_wb_rd] <= i_alu_result;
        end
      end
    end else begin : g_rf_keep
      always_ff @(posedge clk) begin
        if (rst_n && r_wb_valid) r_rf[r_wb_rd] <= i_alu_result;
      end
    end
  endgenerate

  assign o_instr_ready  = w_ready;
  assign o_illegal      = r_illegal;
  assign o_alu_enable   = r_ex_valid;
  assign o_alu_opsel    = r_opsel;
  assign o_alu_code_bus = r_code_bus;
  assign o_alu_pc       = r_pc;
  assign o_alu_s1       = r_s1;
  assign o_alu_s2       = r_s2;
  assign o_wb_valid     = r_wb_valid;
  assign o_wb_rd        = r_wb_rd;
  assign o_wb_data      = r_wb_valid ? i_alu_result : '0;

endmodule
`default_nettype wire

// File: tb/tb_rv32_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_alu_issue
// Brief    : Directed bench with an ISA-level model and a registered ALU model.
// Revision : 1.0
// ============================================================================
module tb_rv32_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_instr_valid = 1'b0;
  logic [31:0] i_instr = 32'd0;
  logic [31:0] i_instr_pc = 32'd0;
  logic [31:0] i_alu_result;
  logic        o_instr_ready, o_illegal, o_alu_enable, o_wb_valid;
  logic [3:0]  o_alu_opsel;
  logic [31:0] o_alu_code_bus, o_alu_pc, o_alu_s1, o_alu_s2, o_wb_data;
  logic [4:0]  o_wb_rd;

  always #5 clk = ~clk;

  rv32_alu_issue #(.XLEN(32), .RF_CLR_RST(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_instr_valid(i_instr_valid), .i_instr(i_instr), .i_instr_pc(i_instr_pc),
    .o_instr_ready(o_instr_ready), .o_illegal(o_illegal),
    .o_alu_enable(o_alu_enable), .o_alu_opsel(o_alu_opsel),
    .o_alu_code_bus(o_alu_code_bus), .o_alu_pc(o_alu_pc),
    .o_alu_s1(o_alu_s1), .o_alu_s2(o_alu_s2), .i_alu_result(i_alu_result),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Architectural decode table of legal ALU instructions.
  function automatic void dec(input logic [31:0] w, output bit legal, output logic [3:0] op,
                              output bit u1, output bit u2);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    legal = 1'b1; op = 4'd0; u1 = 1'b0; u2 = 1'b0;
    if (opc == 7'h33) begin
      u1 = 1'b1; u2 = 1'b1;
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: op = 4'd0;  3'd7: op = 4'd2;  3'd6: op = 4'd3;
          3'd4: op = 4'd4;  3'd2: op = 4'd5;  3'd3: op = 4'd6;
          default: legal = 1'b0;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) op = 4'd1;
      else legal = 1'b0;
    end else if (opc == 7'h13) begin
      u1 = 1'b1;
      case (f3)
        3'd0: op = 4'd7;  3'd7: op = 4'd9;   3'd6: op = 4'd10;
        3'd4: op = 4'd11; 3'd2: op = 4'd12;  3'd3: op = 4'd13;
        default: legal = 1'b0;
      endcase
    end else if (opc == 7'h37) op = 4'd14;
    else if (opc == 7'h17) op = 4'd15;
    else legal = 1'b0;
    if (!legal) begin u1 = 1'b0; u2 = 1'b0; end
  endfunction

  // Instruction semantics straight from the word and register values.
  function automatic logic [31:0] isa(input logic [31:0] w, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] pc);
    logic [31:0] iimm, uimm, o;
    iimm = {{20{w[31]}}, w[31:20]};
    uimm = {w[31:12], 12'h000};
    if (w[6:0] == 7'h37) return uimm;
    if (w[6:0] == 7'h17) return pc + uimm;
    o = (w[6:0] == 7'h33) ? b : iimm;
    case (w[14:12])
      3'd0:    return (w[6:0] == 7'h33 && w[30]) ? a - b : a + o;
      3'd7:    return a & o;
      3'd6:    return a | o;
      3'd4:    return a ^ o;
      3'd2:    return {31'd0, $signed(a) < $signed(o)};
      3'd3:    return {31'd0, a < o};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Stand-in for the registered ALU: result appears the cycle after enable.
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] c,
                                      input logic [31:0] pc);
    logic [31:0] im;
    im = {{20{c[31]}}, c[31:20]};
    case (op)
      4'd0:  return s1 + s2;
      4'd1:  return s1 - s2;
      4'd2:  return s1 & s2;
      4'd3:  return s1 | s2;
      4'd4:  return s1 ^ s2;
      4'd5:  return {31'd0, $signed(s1) < $signed(s2)};
      4'd6:  return {31'd0, s1 < s2};
      4'd7:  return s1 + im;
      4'd9:  return s1 & im;
      4'd10: return s1 | im;
      4'd11: return s1 ^ im;
      4'd12: return {31'd0, $signed(s1) < $signed(im)};
      4'd13: return {31'd0, s1 < im};
      4'd14: return {c[31:12], 12'h000};
      4'd15: return pc + {c[31:12], 12'h000};
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] alu_q = 32'd0;
  always @(posedge clk) if (o_alu_enable) alu_q <= alu(o_alu_opsel, o_alu_s1, o_alu_s2, o_alu_code_bus, o_alu_pc);
  assign i_alu_result = alu_q;

  // Model state: expectations scheduled per cycle index.
  bit          e_en [1024];
  bit          e_ill[1024];
  bit          e_wbv[1024];
  logic [4:0]  e_wbrd[1024];
  logic [31:0] e_wbd[1024];
  logic [31:0] mrf[32];
  logic [3:0]  l_op = 4'd0;
  logic [31:0] l_s1 = 0, l_s2 = 0, l_code = 0, l_pc = 0;
  logic [4:0]  prev_rd = 5'd0;
  int          cyc = 0;
  bit          checking = 1'b0;
  logic [36:0] wb_log[$];
  int          ill_seen = 0;

  always @(negedge clk) begin
    bit lg, u1, u2, hz;
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic [4:0]  rd;
    dec(i_instr, lg, op, u1, u2);
    hz = (prev_rd != 5'd0) && ((u1 && i_instr[19:15] == prev_rd) || (u2 && i_instr[24:20] == prev_rd));
    if (checking) begin
      chk("instr_ready", {31'd0, o_instr_ready}, {31'd0, rst_n && !hz});
      chk("alu_enable",  {31'd0, o_alu_enable},  {31'd0, e_en[cyc]});
      chk("illegal",     {31'd0, o_illegal},     {31'd0, e_ill[cyc]});
      chk("alu_opsel",   {28'd0, o_alu_opsel},   {28'd0, l_op});
      chk("alu_s1",      o_alu_s1,   l_s1);
      chk("alu_s2",      o_alu_s2,   l_s2);
      chk("alu_code_bus", o_alu_code_bus, l_code);
      chk("alu_pc",      o_alu_pc,   l_pc);
      chk("wb_valid",    {31'd0, o_wb_valid},    {31'd0, e_wbv[cyc]});
      if (e_wbv[cyc]) begin
        chk("wb_rd",   {27'd0, o_wb_rd}, {27'd0, e_wbrd[cyc]});
        chk("wb_data", o_wb_data, e_wbd[cyc]);
      end
      if (o_wb_valid) wb_log.push_back({o_wb_rd, o_wb_data});
      if (o_illegal)  ill_seen++;
    end
    if (!rst_n) begin
      checking = 1'b1;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      l_op = 4'd0; l_s1 = 0; l_s2 = 0; l_code = 0; l_pc = 0;
      prev_rd = 5'd0;
      for (int k = 1; k <= 2; k++) begin
        e_en[cyc+k] = 1'b0; e_ill[cyc+k] = 1'b0; e_wbv[cyc+k] = 1'b0;
      end
    end else begin
      prev_rd = 5'd0;
      if (i_instr_valid && o_instr_ready) begin
        if (lg) begin
          a  = u1 ? mrf[i_instr[19:15]] : 32'd0;
          b  = u2 ? mrf[i_instr[24:20]] : 32'd0;
          rd = i_instr[11:7];
          r  = isa(i_instr, a, b, i_instr_pc);
          e_en[cyc+1] = 1'b1;
          l_op = op; l_s1 = a; l_s2 = b; l_code = i_instr; l_pc = i_instr_pc;
          if (rd != 5'd0) begin
            e_wbv[cyc+2] = 1'b1; e_wbrd[cyc+2] = rd; e_wbd[cyc+2] = r;
            mrf[rd] = r;
          end
          prev_rd = rd;
        end else begin
          e_ill[cyc+1] = 1'b1;
        end
      end
    end
    if (cyc < 1000) cyc++;
  end

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    bit done;
    done = 1'b0;
    i_instr_valid = 1'b1; i_instr = w; i_instr_pc = pc;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      if (o_instr_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    i_instr_valid = 1'b0; i_instr = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [36:0] exp_log[$];

  initial begin
    exp_log = '{ {5'd1, 32'd5}, {5'd2, 32'd10}, {5'd3, 32'h12345000}, {5'd4, 32'd5},
                 {5'd5, 32'hFFFFFFFD}, {5'd6, 32'd1}, {5'd7, 32'd0}, {5'd8, 32'd8},
                 {5'd9, 32'hFFFFFFFF}, {5'd10, 32'hFFFFFFF7}, {5'd11, 32'hF0},
                 {5'd12, 32'h705}, {5'd13, 32'd2}, {5'd14, 32'd1}, {5'd15, 32'd0},
                 {5'd16, 32'h1200}, {5'd18, 32'd0} };
    idle(3);
    rst_n = 1'b1;
    idle(1);
    send(32'h00500093, 32'h100);   // addi x1,x0,5
    send(32'h00108133, 32'h104);   // add  x2,x1,x1 (hazard stall)
    send(32'h123451B7, 32'h108);   // lui  x3
    send(32'h40110233, 32'h10C);   // sub  x4,x2,x1 (WB bypass of x2)
    idle(3);
    send(32'h00109093, 32'h110);   // slli: illegal
    idle(3);
    send(32'h00700013, 32'h114);   // addi x0,x0,7
    send(32'h00000033, 32'h118);   // add  x0,x0,x0
    idle(3);
    send(32'h00109133, 32'h11C);   // sll: illegal
    send(32'h02108133, 32'h120);   // add with f7=1: illegal
    send(32'h0010D093, 32'h124);   // srli: illegal
    send(32'h00002083, 32'h128);   // lw: illegal
    idle(2);
    send(32'hFFD00293, 32'h12C);   // addi x5,x0,-3
    send(32'h0012A333, 32'h130);   // slt  x6,x5,x1
    send(32'h0012B3B3, 32'h134);   // sltu x7,x5,x1
    send(32'h0022F433, 32'h138);   // and  x8,x5,x2
    send(32'h0022E4B3, 32'h13C);   // or   x9,x5,x2
    send(32'h0022C533, 32'h140);   // xor  x10,x5,x2
    send(32'h0F02F593, 32'h144);   // andi x11,x5,0xF0
    send(32'h7000E613, 32'h148);   // ori  x12,x1,0x700
    send(32'hFFF2C693, 32'h14C);   // xori x13,x5,-1
    send(32'h0002A713, 32'h150);   // slti x14,x5,0
    send(32'h0012B793, 32'h154);   // sltiu x15,x5,1
    send(32'h00001817, 32'h200);   // auipc x16,1
    idle(4);
    send(32'h00900893, 32'h204);   // addi x17,x0,9 then reset while enabled
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(3);
    send(32'h00208933, 32'h208);   // add x18,x1,x2 after RF clear
    idle(4);
    chk("wb_count", wb_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < wb_log.size(); i++)
      chk("wb_log", wb_log[i][31:0] ^ {27'd0, wb_log[i][36:32]}, exp_log[i][31:0] ^ {27'd0, exp_log[i][36:32]});
    chk("illegal_count", ill_seen, 5);
    chk("model_x4", mrf[4], 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
